memory_arbiter: RTL and testbench

//  Shares the single-ported unified RAM between the instruction-fetch port and the data port.
//  The data port is driven by the control unit's dmemr/dmemw decode.

---
 rtl/memory_arbiter_pkg.sv | 22 ++
 rtl/memory_arbiter_starve_counter.sv | 27 ++
 rtl/memory_arbiter.sv | 161 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the unified-RAM arbiter: word type, FSM states, helpers.
package memory_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        IREAD,
        DREAD,
        DWRITE,
        DONE,
        ERROR
    } arb_state_t;

    // True while a RAM strobe is being driven.
    function automatic logic is_access(arb_state_t s);
        return (s == IREAD) || (s == DREAD) || (s == DWRITE);
    endfunction

endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// Saturating counter of data grants made while a fetch is waiting.
module memory_arbiter_starve_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CNT_W-1:0] r_count;

    assign o_at_max = (r_count >= CNT_W'(MAX));

    // Clear wins over increment; hold once saturated.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and data port.
// Data has priority; a starvation counter forces a fetch grant, and a timeout
// parks the FSM in ERROR if the RAM never answers.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = WORD_W,
    parameter int unsigned DATA_W     = WORD_W,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              memerr
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_port_i;
    logic              w_grant_i;
    logic              w_grant_dr;
    logic              w_grant_dw;
    logic              w_starve_max;

    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign iload    = r_iload;
    assign dload    = r_dload;

    memory_arbiter_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clear  (w_grant_i),
        .i_inc    ((w_grant_dr || w_grant_dw) && iREN),
        .o_at_max (w_starve_max)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant decision, access sequencing and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_dr   = 1'b0;
        w_grant_dw   = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        memerr       = 1'b0;
        case (r_state)
            IDLE: begin
                // A starved fetch overrides data priority; write beats read.
                if (iREN && w_starve_max) begin
                    w_grant_i    = 1'b1;
                    w_state_next = IREAD;
                end else if (dWEN) begin
                    w_grant_dw   = 1'b1;
                    w_state_next = DWRITE;
                end else if (dREN) begin
                    w_grant_dr   = 1'b1;
                    w_state_next = DREAD;
                end else if (iREN) begin
                    w_grant_i    = 1'b1;
                    w_state_next = IREAD;
                end
            end
            IREAD, DREAD, DWRITE: begin
                ramREN = (r_state != DWRITE);
                ramWEN = (r_state == DWRITE);
                if (ramready) begin
                    w_state_next = DONE;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_state_next = ERROR;
                end
            end
            DONE: begin
                iwait        = !r_port_i;
                dwait        = r_port_i;
                w_state_next = IDLE;
            end
            ERROR: begin
                memerr = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address/store capture on grant, timeout count during access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr   <= '0;
            r_store  <= '0;
            r_tmo    <= '0;
            r_port_i <= 1'b0;
        end else begin
            if (w_grant_i) begin
                r_addr   <= iaddr;
                r_port_i <= 1'b1;
            end else if (w_grant_dr || w_grant_dw) begin
                r_addr   <= daddr;
                r_port_i <= 1'b0;
            end
            if (w_grant_dw) begin
                r_store <= dstore;
            end
            if (w_grant_i || w_grant_dr || w_grant_dw) begin
                r_tmo <= '0;
            end else if (is_access(r_state) && !ramready) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end
        end
    end

    // Read data capture; writes leave both load registers untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_iload <= '0;
            r_dload <= '0;
        end else if (ramready && (r_state == IREAD)) begin
            r_iload <= ramload;
        end else if (ramready && (r_state == DREAD)) begin
            r_dload <= ramload;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: transaction-level model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_memory_arbiter;

    localparam int TIMEOUT = 255;
    localparam int SMAX    = 4;
    localparam int K_I     = 1;
    localparam int K_DR    = 2;
    localparam int K_DW    = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ram_rdata = '0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, ramready, memerr;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    memory_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ram_rdata),
        .ramready (ramready),
        .memerr   (memerr)
    );

    always #5 CLK = ~CLK;

    // RAM responder: ready on the ram_lat-th consecutive strobe cycle; 0 = never.
    int ram_lat = 1;
    int ram_cnt = 0;
    always @(posedge CLK) ram_cnt <= (ramREN || ramWEN) ? ram_cnt + 1 : 0;
    assign ramready = (ramREN || ramWEN) && (ram_lat != 0) && (ram_cnt == ram_lat - 1);

    // Transaction model: one access in flight, then one completion cycle, then free.
    bit          m_active = 0, m_done = 0, m_err = 0;
    int          m_kind = 0, m_starve = 0, m_age = 0;
    logic [31:0] m_addr = '0, m_store = '0, m_iload = '0, m_dload = '0;

    always @(posedge CLK) begin : model
        bit          act, dn, er;
        int          kind, stv, age;
        logic [31:0] ad, st, il, dl;
        act = m_active; dn = m_done; er = m_err; kind = m_kind; stv = m_starve;
        age = m_age; ad = m_addr; st = m_store; il = m_iload; dl = m_dload;
        if (RST) begin
            act = 0; dn = 0; er = 0; kind = 0; stv = 0; age = 0;
            ad = '0; st = '0; il = '0; dl = '0;
        end else if (er) begin
            act = 0;
        end else if (dn) begin
            dn = 0;
        end else if (act) begin
            if (ramready) begin
                if (kind == K_I) il = ram_rdata;
                if (kind == K_DR) dl = ram_rdata;
                act = 0;
                dn  = 1;
            end else begin
                age = age + 1;
                if (age >= TIMEOUT) begin
                    er  = 1;
                    act = 0;
                end
            end
        end else begin
            kind = 0;
            if (iREN && stv >= SMAX) kind = K_I;
            else if (dWEN)           kind = K_DW;
            else if (dREN)           kind = K_DR;
            else if (iREN)           kind = K_I;
            if (kind != 0) begin
                act = 1;
                age = 0;
                ad  = (kind == K_I) ? iaddr : daddr;
                if (kind == K_DW) st = dstore;
                if (kind == K_I) stv = 0;
                else if (iREN && stv < SMAX) stv = stv + 1;
            end
        end
        m_active <= act; m_done <= dn; m_err <= er; m_kind <= kind; m_starve <= stv;
        m_age <= age; m_addr <= ad; m_store <= st; m_iload <= il; m_dload <= dl;
    end

    logic [4:0] e_ctl, a_ctl;
    assign e_ctl = {m_active && (m_kind != K_DW), m_active && (m_kind == K_DW),
                    !(m_done && m_kind == K_I), !(m_done && m_kind != K_I), m_err};
    assign a_ctl = {ramREN, ramWEN, iwait, dwait, memerr};

    // Per-cycle compare against the model, plus event monitors for directed checks.
    int          n_ren = 0, n_wen = 0, n_ilow = 0, n_dlow = 0;
    logic [31:0] wen_addr = '0, wen_store = '0;
    int          pulse_log[$];

    always @(negedge CLK) begin
        if (cmp_en) begin
            n_checks++;
            if (a_ctl !== e_ctl || ramaddr !== m_addr || ramstore !== m_store ||
                iload !== m_iload || dload !== m_dload) begin
                n_err++;
                $display("FAIL model t=%0t got ctl=%b addr=%h st=%h il=%h dl=%h expected ctl=%b addr=%h st=%h il=%h dl=%h",
                         $time, a_ctl, ramaddr, ramstore, iload, dload,
                         e_ctl, m_addr, m_store, m_iload, m_dload);
            end
        end
        if (ramREN) n_ren++;
        if (ramWEN) begin
            n_wen++;
            wen_addr  = ramaddr;
            wen_store = ramstore;
        end
        if (!iwait) begin n_ilow++; pulse_log.push_back(K_I); end
        if (!dwait) begin n_dlow++; pulse_log.push_back(K_DR); end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_ren = 0; n_wen = 0; n_ilow = 0; n_dlow = 0;
        pulse_log.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    task automatic wait_pulses(input int n, input int max_cyc, input string name);
        int k = 0;
        while (pulse_log.size() < n && k < max_cyc) begin
            step(1);
            k++;
        end
        chk(name, 64'(pulse_log.size() >= n), 64'd1);
    endtask

    initial begin
        step(2);
        cmp_en = 1'b1;
        chk("rst_ctl", 64'({ramREN, ramWEN, iwait, dwait, memerr}), 64'b00110);
        chk("rst_addr", 64'(ramaddr), 64'h0);
        RST = 1'b0;
        step(1);

        // 1: fetch, RAM ready on second strobe cycle
        clr_mon();
        ram_lat = 2; ram_rdata = 32'h0050_0093;
        iREN = 1'b1; iaddr = 32'h100;
        wait_pulses(1, 20, "t1_wait");
        iREN = 1'b0;
        step(3);
        chk("t1_ren_cycles", 64'(n_ren), 64'd2);
        chk("t1_iload", 64'(iload), 64'h0050_0093);
        chk("t1_iwait_low", 64'(n_ilow), 64'd1);

        // 2: write, RAM ready immediately
        clr_mon();
        ram_lat = 1;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        wait_pulses(1, 20, "t2_wait");
        dWEN = 1'b0;
        step(3);
        chk("t2_wen_cycles", 64'(n_wen), 64'd1);
        chk("t2_ramaddr", 64'(wen_addr), 64'h200);
        chk("t2_ramstore", 64'(wen_store), 64'hDEAD_BEEF);
        chk("t2_dwait_low", 64'(n_dlow), 64'd1);
        chk("t2_no_ren", 64'(n_ren), 64'd0);

        // 3: simultaneous fetch and data read, data first
        clr_mon();
        ram_lat = 3; ram_rdata = 32'h1234_5678;
        iREN = 1'b1; iaddr = 32'h104; dREN = 1'b1; daddr = 32'h300;
        wait_pulses(1, 30, "t3_wait_d");
        dREN = 1'b0;
        wait_pulses(2, 30, "t3_wait_i");
        iREN = 1'b0;
        step(2);
        chk("t3_first", 64'(pulse_log[0]), 64'(K_DR));
        chk("t3_second", 64'(pulse_log[1]), 64'(K_I));
        chk("t3_dload", 64'(dload), 64'h1234_5678);

        // 4: fetch starved by four data grants, then served
        clr_mon();
        ram_lat = 1; ram_rdata = 32'hCAFE_0001;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h108; daddr = 32'h400;
        wait_pulses(5, 60, "t4_wait");
        iREN = 1'b0; dREN = 1'b0;
        step(2);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_grant%0d", i), 64'(pulse_log[i]), 64'(K_DR));
        chk("t4_grant4", 64'(pulse_log[4]), 64'(K_I));
        clr_mon();
        iREN = 1'b1; dREN = 1'b1;
        wait_pulses(1, 20, "t4_after_wait");
        iREN = 1'b0; dREN = 1'b0;
        step(2);
        chk("t4_cleared", 64'(pulse_log[0]), 64'(K_DR));

        // 5: RAM never ready -> sticky error
        clr_mon();
        ram_lat = 0;
        dREN = 1'b1; daddr = 32'h500;
        for (int k = 0; k < 300 && !memerr; k++) step(1);
        dREN = 1'b0;
        chk("t5_memerr", 64'(memerr), 64'd1);
        chk("t5_ren_cycles", 64'(n_ren), 64'(TIMEOUT));
        clr_mon();
        iREN = 1'b1;
        step(10);
        chk("t5_hold_err", 64'({ramREN, ramWEN, iwait, dwait, memerr}), 64'b00111);
        chk("t5_no_strobe", 64'(n_ren + n_wen + n_ilow + n_dlow), 64'd0);
        RST = 1'b1; iREN = 1'b0;
        step(1);
        RST = 1'b0;
        chk("t5_rst_clears", 64'(memerr), 64'd0);

        // 6: reset pulsed mid-write
        ram_lat = 0;
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'h0BAD_F00D;
        step(3);
        chk("t6_in_write", 64'({ramWEN, ramaddr}), {31'd0, 1'b1, 32'h600});
        RST = 1'b1; dWEN = 1'b0;
        step(1);
        RST = 1'b0;
        chk("t6_rst_ctl", 64'({ramREN, ramWEN, iwait, dwait, memerr}), 64'b00110);
        chk("t6_rst_addr_store", {ramaddr, ramstore}, 64'h0);
        chk("t6_rst_loads", {iload, dload}, 64'h0);
        step(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
